// File: rtl/pay_ctrl.sv
// pay_ctrl: coin-operated payment controller with BCD price, credit, change and countdown.
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   start, cancel              one-cycle pulses: begin / abort a payment
//   coin1, coin5, coin10       one-cycle coin-accepted pulses (value 1/5/10)
//   cost_one, cost_ten         BCD price, sampled when start is accepted
//   pay_en                     high while a payment is in progress
//   paid_one, paid_ten         BCD credit so far (saturates at 99)
//   time_one, time_ten         BCD seconds remaining
//   change_one, change_ten     BCD change / refund amount
//   dispense, refund           one-cycle result pulses
//
// Optional feature: define PAY_CTRL_TIMEOUT_EN to enable the per-second timeout countdown.
// Without it the time outputs are constant TIMEOUT_S and PAY ends only on payment or cancel.
module pay_ctrl #(
  parameter int unsigned CLK_PER_SEC = 100_000_000,
  parameter int unsigned TIMEOUT_S   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       coin1,
  input  logic       coin5,
  input  logic       coin10,
  input  logic [3:0] cost_one,
  input  logic [3:0] cost_ten,
  output logic       pay_en,
  output logic [3:0] paid_one,
  output logic [3:0] paid_ten,
  output logic [3:0] time_one,
  output logic [3:0] time_ten,
  output logic [3:0] change_one,
  output logic [3:0] change_ten,
  output logic       dispense,
  output logic       refund
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StPay      = 2'd1;
  localparam logic [1:0] StDispense = 2'd2;
  localparam logic [1:0] StRefund   = 2'd3;

  localparam logic [3:0] TimeTen = 4'(TIMEOUT_S / 10);
  localparam logic [3:0] TimeOne = 4'(TIMEOUT_S % 10);

  logic [1:0] state_q, state_d;
  logic [3:0] cost_one_q, cost_one_d, cost_ten_q, cost_ten_d;
  logic [3:0] paid_one_q, paid_one_d, paid_ten_q, paid_ten_d;
  logic [3:0] chg_one_q, chg_one_d, chg_ten_q, chg_ten_d;
  logic       pay_en_q, pay_en_d, dispense_q, dispense_d, refund_q, refund_d;
  logic       timeout;

  // Coin credit: only one coin per cycle, coin10 > coin5 > coin1.
  logic       coin_any, add_ten, carry, ten_inc;
  logic [3:0] add_one, sum_one, sum_ten;
  logic [4:0] raw_one;

  always_comb begin
    coin_any = coin10 | coin5 | coin1;
    add_ten  = coin10;
    add_one  = coin10 ? 4'd0 : (coin5 ? 4'd5 : (coin1 ? 4'd1 : 4'd0));
    raw_one  = {1'b0, paid_one_q} + {1'b0, add_one};
    carry    = raw_one > 5'd9;
    ten_inc  = add_ten | carry;
    if (ten_inc && paid_ten_q == 4'd9) begin
      sum_ten = 4'd9;
      sum_one = 4'd9;
    end else begin
      sum_ten = paid_ten_q + {3'b000, ten_inc};
      sum_one = carry ? 4'(raw_one - 5'd10) : raw_one[3:0];
    end
  end

  // Post-coin credit vs. latched price and BCD difference (used only when credit >= price).
  logic [3:0] nxt_one, nxt_ten, diff_one, diff_ten;
  logic       enough, borrow;

  always_comb begin
    nxt_one  = coin_any ? sum_one : paid_one_q;
    nxt_ten  = coin_any ? sum_ten : paid_ten_q;
    enough   = (nxt_ten > cost_ten_q) || (nxt_ten == cost_ten_q && nxt_one >= cost_one_q);
    borrow   = nxt_one < cost_one_q;
    diff_one = 4'({1'b0, nxt_one} + (borrow ? 5'd10 : 5'd0) - {1'b0, cost_one_q});
    diff_ten = nxt_ten - cost_ten_q - {3'b000, borrow};
  end

`ifdef PAY_CTRL_TIMEOUT_EN
  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    time_one_q, time_one_d, time_ten_q, time_ten_d;
  logic          tick;

  always_comb begin
    presc_d    = presc_q;
    time_one_d = time_one_q;
    time_ten_d = time_ten_q;
    tick       = 1'b0;
    timeout    = 1'b0;
    if (state_q == StIdle && start) begin
      presc_d    = '0;
      time_one_d = TimeOne;
      time_ten_d = TimeTen;
    end else if (state_q == StPay) begin
      if (presc_q == PW'(CLK_PER_SEC - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      if (tick) begin
        if (time_one_q == 4'd0 && time_ten_q == 4'd0) begin
          timeout = 1'b1;
        end else if (time_one_q == 4'd0) begin
          time_one_d = 4'd9;
          time_ten_d = time_ten_q - 4'd1;
        end else begin
          time_one_d = time_one_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      time_one_q <= TimeOne;
      time_ten_q <= TimeTen;
    end else begin
      presc_q    <= presc_d;
      time_one_q <= time_one_d;
      time_ten_q <= time_ten_d;
    end
  end

  assign time_one = time_one_q;
  assign time_ten = time_ten_q;
`else
  assign timeout  = 1'b0;
  assign time_one = TimeOne;
  assign time_ten = TimeTen;
`endif

  always_comb begin
    state_d    = state_q;
    cost_one_d = cost_one_q;
    cost_ten_d = cost_ten_q;
    paid_one_d = paid_one_q;
    paid_ten_d = paid_ten_q;
    chg_one_d  = chg_one_q;
    chg_ten_d  = chg_ten_q;
    pay_en_d   = 1'b0;
    dispense_d = 1'b0;
    refund_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StPay;
          pay_en_d   = 1'b1;
          cost_one_d = (cost_one > 4'd9) ? 4'd9 : cost_one;
          cost_ten_d = (cost_ten > 4'd9) ? 4'd9 : cost_ten;
          paid_one_d = 4'd0;
          paid_ten_d = 4'd0;
          chg_one_d  = 4'd0;
          chg_ten_d  = 4'd0;
        end
      end
      StPay: begin
        paid_one_d = nxt_one;
        paid_ten_d = nxt_ten;
        // A coin arriving with cancel/timeout is credited first and may still complete payment.
        if (enough) begin
          state_d    = StDispense;
          dispense_d = 1'b1;
          chg_one_d  = diff_one;
          chg_ten_d  = diff_ten;
        end else if (cancel || timeout) begin
          state_d   = StRefund;
          refund_d  = 1'b1;
          chg_one_d = nxt_one;
          chg_ten_d = nxt_ten;
        end else begin
          pay_en_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cost_one_q <= 4'd0;
      cost_ten_q <= 4'd0;
      paid_one_q <= 4'd0;
      paid_ten_q <= 4'd0;
      chg_one_q  <= 4'd0;
      chg_ten_q  <= 4'd0;
      pay_en_q   <= 1'b0;
      dispense_q <= 1'b0;
      refund_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cost_one_q <= cost_one_d;
      cost_ten_q <= cost_ten_d;
      paid_one_q <= paid_one_d;
      paid_ten_q <= paid_ten_d;
      chg_one_q  <= chg_one_d;
      chg_ten_q  <= chg_ten_d;
      pay_en_q   <= pay_en_d;
      dispense_q <= dispense_d;
      refund_q   <= refund_d;
    end
  end

  assign pay_en     = pay_en_q;
  assign dispense   = dispense_q;
  assign refund     = refund_q;
  assign paid_one   = paid_one_q;
  assign paid_ten   = paid_ten_q;
  assign change_one = chg_one_q;
  assign change_ten = chg_ten_q;

endmodule
